// File: rtl/fpc_rr_sched.sv
// Per-channel FPC read-request scheduler: issues sequential 512-byte reads up to a
// host stop pointer, bounded by outstanding-read and receive-FIFO credit limits.
`timescale 1ns/1ps
module fpc_rr_sched #(
    parameter logic [12:0] PIO_STOP = 13'd16,
    parameter logic [12:0] PIO_SRST = 13'd17,
    parameter int unsigned MAX_OUT  = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        pio_wvalid,
    input  logic [63:0] pio_wdata,
    input  logic [12:0] pio_addr,
    input  logic [9:0]  fifo_free,
    input  logic        cpl_done,
    output logic        rr_valid,
    output logic [63:0] rr_addr,
    input  logic        rr_ready,
    output logic [3:0]  outstanding,
    output logic [16:0] rr_block,
    output logic        busy
);

    localparam int unsigned BLK_W  = 17;
    localparam int unsigned OUT_W  = 4;
    localparam int unsigned FREE_W = 10;
    localparam int unsigned CMP_W  = FREE_W + 1;

    typedef enum logic {IDLE, REQ} state_t;

    state_t             state, state_next;
    logic               rr_valid_next;
    logic [BLK_W-1:0]   stop, stop_next, block_next;
    logic [OUT_W-1:0]   out_next;
    logic               busy_next;
    logic               stop_wr, srst_wr, handshake, cpl_take, elig;
    logic               unused_wdata;

    assign stop_wr   = pio_wvalid && (pio_addr == PIO_STOP);
    assign srst_wr   = pio_wvalid && (pio_addr == PIO_SRST);
    assign handshake = rr_valid && rr_ready;
    // A completion with nothing in flight is stray and must not underflow the count
    assign cpl_take  = cpl_done && (outstanding != '0);
    assign elig      = (rr_block != stop)
                    && (outstanding < OUT_W'(MAX_OUT))
                    && ({1'b0, fifo_free} > CMP_W'(outstanding));

    assign rr_addr      = {38'd0, rr_block, 9'd0};
    assign unused_wdata = ^{pio_wdata[63:26], pio_wdata[8:0]};

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            rr_valid <= 1'b0;
        end else begin
            state    <= state_next;
            rr_valid <= rr_valid_next;
        end
    end

    // Next-state logic; soft reset overrides any transition
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (elig) state_next = REQ;
            REQ:     if (rr_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (srst_wr) state_next = IDLE;
    end

    // Output / datapath next values
    always_comb begin
        rr_valid_next = (state_next == REQ);
        block_next    = rr_block;
        stop_next     = stop;
        out_next      = outstanding;
        if (handshake) block_next = rr_block + BLK_W'(1);
        if (stop_wr)   stop_next  = pio_wdata[25:9];
        if (srst_wr) begin
            block_next = '0;
            stop_next  = '0;
        end
        case ({handshake, cpl_take})
            2'b10:   out_next = outstanding + OUT_W'(1);
            2'b01:   out_next = outstanding - OUT_W'(1);
            default: out_next = outstanding;
        endcase
        busy_next = (block_next != stop_next) || (out_next != '0);
    end

    // Datapath registers; outstanding survives soft reset so in-flight reads drain
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rr_block    <= '0;
            stop        <= '0;
            outstanding <= '0;
            busy        <= 1'b0;
        end else begin
            rr_block    <= block_next;
            stop        <= stop_next;
            outstanding <= out_next;
            busy        <= busy_next;
        end
    end

endmodule

// File: tb/tb_fpc_rr_sched.sv
// Directed self-checking bench for fpc_rr_sched.
`timescale 1ns/1ps
module tb_fpc_rr_sched;

    logic        clock = 1'b0;
    logic        reset;
    logic        pio_wvalid;
    logic [63:0] pio_wdata;
    logic [12:0] pio_addr;
    logic [9:0]  fifo_free;
    logic        cpl_done;
    logic        rr_valid;
    logic [63:0] rr_addr;
    logic        rr_ready;
    logic [3:0]  outstanding;
    logic [16:0] rr_block;
    logic        busy;

    fpc_rr_sched dut (
        .clock       (clock),
        .reset       (reset),
        .pio_wvalid  (pio_wvalid),
        .pio_wdata   (pio_wdata),
        .pio_addr    (pio_addr),
        .fifo_free   (fifo_free),
        .cpl_done    (cpl_done),
        .rr_valid    (rr_valid),
        .rr_addr     (rr_addr),
        .rr_ready    (rr_ready),
        .outstanding (outstanding),
        .rr_block    (rr_block),
        .busy        (busy)
    );

    always #5 clock = ~clock;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          hs_total = 0;
    logic [63:0] addr_log [0:255];
    int          cyc_log  [0:255];
    int          base;

    always @(posedge clock) cyc <= cyc + 1;

    // Log every accepted request with its address and cycle
    always @(posedge clock) begin
        if (rr_valid && rr_ready) begin
            if (hs_total < 256) begin
                addr_log[hs_total] <= rr_addr;
                cyc_log[hs_total]  <= cyc;
            end
            hs_total <= hs_total + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        pio_wvalid = 1'b0;
        pio_wdata  = '0;
        pio_addr   = '0;
        fifo_free  = '0;
        cpl_done   = 1'b0;
        rr_ready   = 1'b0;
        tick_n(2);
        reset = 1'b0;
    endtask

    task automatic pio_write(input logic [12:0] addr, input logic [63:0] data);
        pio_addr   = addr;
        pio_wdata  = data;
        pio_wvalid = 1'b1;
        tick();
        pio_wvalid = 1'b0;
        pio_addr   = '0;
        pio_wdata  = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] exp_addr [0:3];
        exp_addr[0] = 64'h0;
        exp_addr[1] = 64'h200;
        exp_addr[2] = 64'h400;
        exp_addr[3] = 64'h600;

        // Reset state and stray completion
        do_reset();
        check("rst_valid", 64'(rr_valid), 64'd0);
        check("rst_block", 64'(rr_block), 64'd0);
        check("rst_out",   64'(outstanding), 64'd0);
        check("rst_busy",  64'(busy), 64'd0);
        check("rst_addr",  rr_addr, 64'd0);
        cpl_done = 1'b1; tick(); cpl_done = 1'b0;
        check("cpl_at_zero", 64'(outstanding), 64'd0);

        // Stop pointer limits issue to 4 blocks, one request every 2 cycles
        fifo_free = 10'd100; rr_ready = 1'b1;
        base = hs_total;
        pio_write(13'd16, 64'h800);
        tick_n(20);
        check("stop4_count", 64'(hs_total - base), 64'd4);
        for (int i = 0; i < 4; i++) check("stop4_addr", addr_log[base+i], exp_addr[i]);
        for (int i = 0; i < 3; i++) check("stop4_gap", 64'(cyc_log[base+i+1] - cyc_log[base+i]), 64'd2);
        check("stop4_valid", 64'(rr_valid), 64'd0);
        check("stop4_out",   64'(outstanding), 64'd4);
        check("stop4_busy",  64'(busy), 64'd1);
        check("stop4_block", 64'(rr_block), 64'd4);

        // Outstanding cap of 8, then one completion releases one request
        do_reset();
        fifo_free = 10'd100; rr_ready = 1'b1;
        base = hs_total;
        pio_write(13'd16, 64'h2800);
        tick_n(30);
        check("cap_count", 64'(hs_total - base), 64'd8);
        check("cap_out",   64'(outstanding), 64'd8);
        check("cap_valid", 64'(rr_valid), 64'd0);
        cpl_done = 1'b1; tick(); cpl_done = 1'b0;
        check("cap_cpl_out", 64'(outstanding), 64'd7);
        tick_n(10);
        check("cap_count9", 64'(hs_total - base), 64'd9);
        check("cap_addr9",  addr_log[base+8], 64'h1000);
        check("cap_out8",   64'(outstanding), 64'd8);
        check("cap_block",  64'(rr_block), 64'd9);

        // FIFO space limits issue
        do_reset();
        fifo_free = 10'd2; rr_ready = 1'b1;
        base = hs_total;
        pio_write(13'd16, 64'h1400);
        tick_n(20);
        check("fifo2_count", 64'(hs_total - base), 64'd2);
        check("fifo2_out",   64'(outstanding), 64'd2);
        fifo_free = 10'd5;
        tick_n(20);
        check("fifo5_count", 64'(hs_total - base), 64'd5);
        check("fifo5_out",   64'(outstanding), 64'd5);
        check("fifo5_valid", 64'(rr_valid), 64'd0);

        // Backpressure: request held stable, one ready pulse gives one increment
        do_reset();
        fifo_free = 10'd100; rr_ready = 1'b0;
        base = hs_total;
        pio_write(13'd16, 64'h2800);
        tick();
        check("bp_valid", 64'(rr_valid), 64'd1);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_addr_hold", rr_addr, 64'd0);
        end
        check("bp_valid_hold", 64'(rr_valid), 64'd1);
        check("bp_block_hold", 64'(rr_block), 64'd0);
        rr_ready = 1'b1; tick(); rr_ready = 1'b0;
        tick_n(10);
        check("bp_count", 64'(hs_total - base), 64'd1);
        check("bp_block", 64'(rr_block), 64'd1);
        check("bp_addr",  rr_addr, 64'h200);
        check("bp_valid2", 64'(rr_valid), 64'd1);
        check("bp_out",   64'(outstanding), 64'd1);

        // Handshake coincident with completion at outstanding 3
        do_reset();
        fifo_free = 10'd100; rr_ready = 1'b0;
        pio_write(13'd16, 64'h2800);
        tick();
        for (int i = 0; i < 3; i++) begin
            rr_ready = 1'b1; tick(); rr_ready = 1'b0; tick();
        end
        check("co_out_pre",   64'(outstanding), 64'd3);
        check("co_valid_pre", 64'(rr_valid), 64'd1);
        rr_ready = 1'b1; cpl_done = 1'b1; tick(); rr_ready = 1'b0; cpl_done = 1'b0;
        check("co_out",   64'(outstanding), 64'd3);
        check("co_block", 64'(rr_block), 64'd4);

        // Soft reset mid-request keeps outstanding
        tick();
        check("srst_pre_valid", 64'(rr_valid), 64'd1);
        pio_write(13'd17, 64'h0);
        check("srst_valid", 64'(rr_valid), 64'd0);
        check("srst_block", 64'(rr_block), 64'd0);
        check("srst_out",   64'(outstanding), 64'd3);
        check("srst_busy",  64'(busy), 64'd1);
        check("srst_addr",  rr_addr, 64'd0);

        // Soft reset coincident with handshake: block clears, outstanding still counts
        pio_write(13'd16, 64'h2800);
        tick();
        check("srhs_pre_valid", 64'(rr_valid), 64'd1);
        rr_ready = 1'b1;
        pio_write(13'd17, 64'h0);
        rr_ready = 1'b0;
        check("srhs_out",   64'(outstanding), 64'd4);
        check("srhs_block", 64'(rr_block), 64'd0);
        check("srhs_valid", 64'(rr_valid), 64'd0);

        // Asynchronous hard reset mid-cycle
        pio_write(13'd16, 64'h2800);
        tick();
        check("ar_pre_valid", 64'(rr_valid), 64'd1);
        #3;
        reset = 1'b1;
        #1;
        check("ar_valid", 64'(rr_valid), 64'd0);
        check("ar_block", 64'(rr_block), 64'd0);
        check("ar_out",   64'(outstanding), 64'd0);
        check("ar_busy",  64'(busy), 64'd0);
        check("ar_addr",  rr_addr, 64'd0);
        tick();
        reset = 1'b0;
        tick_n(3);
        check("ar_idle_valid", 64'(rr_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

endmodule
